stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/pause/clear controller for a cascade of decade counters. The block times a count with a programmable prescaler, sequences the chained BCD digit counters (0–9 each, ripple carry through enables), and provides a lap-freeze display register. It sits between the debounced push-button pulses and the 7-segment display decoder.

## Interface

**Parameters**
- `DIGITS`, default 4: number of cascaded BCD digits (≥1).
- `TICK_DIV`, default 4: clock cycles per count increment while running (≥2).

**Ports**
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start_stop`  in  1  one-cycle pulse; toggles between run and pause.
- `clear`  in  1  one-cycle pulse; zeroes count, prescaler and lap.
- `lap`  in  1  one-cycle pulse; toggles display freeze while running.
- `bcd`  out  4*DIGITS  displayed value. Digit 0 (units) is in bits [3:0].
- `running`  out  1  high in RUN.
- `lap_active`  out  1  high while the display is frozen.
- `overflow`  out  1  one-cycle pulse when the count wraps.

## Operation

**FSM states:** IDLE, RUN, PAUSE.
- IDLE: `start_stop` goes to RUN.
- RUN: `start_stop` goes to PAUSE.
- PAUSE: `start_stop` goes to RUN.
- `clear` in any state goes to IDLE.

**Reset** (`rst`=1 at an edge): state IDLE, all digits 0, prescaler 0, lap register 0. Outputs: `bcd`=0, `running`=0, `lap_active`=0, `overflow`=0. Reset mid-count discards everything.

**Prescaler** `pre`:
- Counts 0..TICK_DIV-1 only in RUN.
- Holds its value in PAUSE, so a resumed interval keeps its partial count.
- Cleared by `clear`/`rst`.
- `tick` = RUN && `pre`==TICK_DIV-1. On a tick, `pre` returns to 0.

**Digits:**
- Digit 0 is enabled by `tick`. Digit k is enabled by `tick` && all lower digits == 9.
- An enabled digit at 9 goes to 0; otherwise it increments.
- Values 10–15 are never reachable.

**Overflow:** a tick with every digit at 9 wraps all digits to 0 and asserts `overflow` for exactly one cycle. The block stays in RUN.

**Lap:**
- `lap` in RUN with `lap_active`=0 captures the current count into the lap register and sets `lap_active`.
- `lap` with `lap_active`=1 clears it.
- `lap` in IDLE or PAUSE while `lap_active`=0 is ignored. Counting continues underneath.
- `bcd` = `lap_active` ? lap register : live count.

**Simultaneous events:**
- `rst` beats `clear`, which beats `start_stop` and `lap`. Lower-priority inputs in the same cycle are ignored.
- `start_stop` and `lap` together in RUN: both take effect. The captured value is the count before this edge.
- A tick coincident with `start_stop` in RUN: the increment still happens, then PAUSE.

## Timing

- All outputs are registered. No combinational path from inputs to outputs.
- `start_stop` sampled at edge n: `running`=1 after edge n. `pre` is 0 at that point (from IDLE).
- First increment is visible after edge n+TICK_DIV. Subsequent increments follow every TICK_DIV cycles.
- `clear` at edge n: `bcd`=0, `running`=0, `lap_active`=0 after edge n.
- Lap capture: the frozen value appears on `bcd` after the same edge.
- `overflow` is high in the cycle after the wrapping edge, then low.

## Structure

**Shared package** (`stopwatch_pkg`):
- State enum (IDLE/RUN/PAUSE).
- Constant `BCD_MAX` = 4'd9.
- Function for the all-nines test.

**Sub-module** `bcd_digit`:
- Ports: `clk`, `rst`, `clr`, `en`, `q[3:0]`, `at_max`.
- Synchronous reset and clear, increment 0–9 with wrap.
- Instantiated DIGITS times via generate. The enable chain is built in `stopwatch_ctrl`.

The controller holds the FSM, prescaler, lap register and overflow flag.

## Test plan

All scenarios use DIGITS=4, TICK_DIV=4.

- **Reset:** `rst` 1 for 2 cycles → `bcd`=0x0000, `running`=0, `lap_active`=0, `overflow`=0.
- **Start timing:** `start_stop` pulse at edge 1 → `running`=1 after edge 1; `bcd`=0x0001 after edge 5; `bcd`=0x0010 after edge 41.
- **Pause and resume:** pause with `pre`=2, hold 10 cycles → `bcd` unchanged. Resume → next increment 2 cycles after resume.
- **Wrap:** preload by running to 0x9999, then one more tick → `bcd`=0x0000, `overflow` high for exactly 1 cycle, `running` stays 1.
- **Lap:** `lap` at count 0x0007 → `bcd` holds 0x0007 for 20 cycles. Second `lap` → `bcd` shows the live count (0x0012).
- **Priority:** `clear`+`start_stop` in the same cycle while in RUN → IDLE, `bcd`=0. `start_stop`+`lap` together in RUN → PAUSE, `lap_active`=1.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//
// Shared definitions for the stopwatch controller and its BCD digit counters.
//
// Contents:
//   sw_state_t  - controller state (IDLE / RUN / PAUSE)
//   BCD_MAX     - terminal value of one decade counter (9)
//   MAX_DIGITS  - widest digit cascade the all-nines helper supports
//   all_nines() - true when the lowest n digits of a packed BCD vector are 9
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Upper bound on DIGITS. Callers zero-extend their count vector to this
  // width so one function body serves any cascade length.
  localparam int MAX_DIGITS = 16;

  // Returns 1 when digits [n-1:0] of 'digits' all hold 9. With n == 0 the
  // condition is vacuously true, which is what the units digit needs: it is
  // enabled by the tick alone.
  function automatic logic all_nines(input logic [4*MAX_DIGITS-1:0] digits,
                                     input int                      n);
    logic result;
    result = 1'b1;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if ((k < n) && (digits[4*k +: 4] != BCD_MAX)) begin
        result = 1'b0;
      end
    end
    return result;
  endfunction

endpackage : stopwatch_pkg

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//
// One decade counter of the stopwatch cascade. Counts 0..9 and wraps to 0
// when enabled at 9. Values 10..15 cannot be reached from reset.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset
//   clr     in   synchronous clear (same effect as reset, driven by control)
//   en      in   count enable for this cycle
//   q       out  current digit value, 0..9
//   at_max  out  high while q == 9
// -----------------------------------------------------------------------------
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       at_max
);

  assign at_max = (q == BCD_MAX);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would let ordering leak into behaviour.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= at_max ? 4'd0 : q + 4'd1;
    end
  end

endmodule : bcd_digit

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Run/pause/clear controller for a cascade of BCD decade counters, sitting
// between debounced push-button pulses and the 7-segment decoder.
//
// A prescaler divides the clock by TICK_DIV while running; each tick advances
// the digit cascade by one. A lap register can freeze the displayed value
// while counting continues underneath.
//
// Parameters:
//   DIGITS    number of cascaded BCD digits (1..MAX_DIGITS)
//   TICK_DIV  clock cycles per count increment while running (>= 2)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start_stop  in   one-cycle pulse, toggles run / pause (IDLE -> RUN)
//   clear       in   one-cycle pulse, zeroes count, prescaler and lap
//   lap         in   one-cycle pulse, toggles display freeze
//   bcd         out  displayed value, digit 0 (units) in bits [3:0]
//   running     out  high in RUN
//   lap_active  out  high while the display is frozen
//   overflow    out  one-cycle pulse after the count wraps to zero
//
// Priority per edge: rst > clear > {start_stop, lap}. start_stop and lap in
// the same RUN cycle both act; the lap captures the pre-edge count.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  running,
  output logic                  lap_active,
  output logic                  overflow
);

  localparam int              PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_t             state;
  logic [PRE_W-1:0]      pre;
  logic                  tick;
  logic [DIGITS-1:0]     dig_en;
  logic [DIGITS-1:0]     dig_max;
  logic [4*DIGITS-1:0]   count;
  logic [4*DIGITS-1:0]   lap_reg;
  logic [4*MAX_DIGITS-1:0] count_pad;

  // A tick is the last prescaler cycle of a counting interval. Because it is
  // qualified by the registered state, a start_stop that pauses on the same
  // edge does not cancel the increment already due.
  assign tick = (state == RUN) && (pre == PRE_LAST);

  // NOTE: combinational blocks assign every output a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    count_pad               = '0;
    count_pad[4*DIGITS-1:0] = count;
  end

  // Enable chain: digit k advances on a tick when every lower digit is at 9.
  // Wrapping of each digit is local to bcd_digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign dig_en[g] = tick && all_nines(count_pad, g);

    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .clr    (clear),
      .en     (dig_en[g]),
      .q      (count[4*g +: 4]),
      .at_max (dig_max[g])
    );
  end

  // Controller: FSM, prescaler, lap register and overflow flag. The digits
  // clear themselves from the same clear pulse, so they agree with this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      running    <= 1'b0;
      pre        <= '0;
      // NOTE: lap_reg is a data register, but it is reset because it can be
      // driven straight onto bcd; stale contents must never reach the display.
      lap_reg    <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      running    <= 1'b0;
      pre        <= '0;
      lap_reg    <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Every digit at 9 on a tick means the whole cascade wraps this edge.
      overflow <= tick && (&dig_max);

      // Prescaler advances only in RUN and holds in PAUSE, so a resumed
      // interval keeps its partial count.
      if (state == RUN) begin
        pre <= tick ? '0 : pre + PRE_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      // Releasing a freeze is allowed in any state; capturing only in RUN.
      // The capture reads the pre-edge count, even if this edge also ticks.
      if (lap) begin
        if (lap_active) begin
          lap_active <= 1'b0;
        end else if (state == RUN) begin
          lap_reg    <= count;
          lap_active <= 1'b1;
        end
      end
    end
  end

  // Both mux inputs and the select are flops, so bcd has no input-to-output
  // combinational path.
  assign bcd = lap_active ? lap_reg : count;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl with DIGITS=4, TICK_DIV=4.
// Each scenario task builds a list of steps (an input pulse and/or a number
// of clock edges to wait). The expected output snapshot is pushed onto a
// scoreboard queue when the step is driven and popped for comparison once
// the DUT has had the edges to respond. Outputs are sampled 1 ns after the
// rising edge; inputs change at the same point and are seen on the next edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_stop;
  logic                clear;
  logic                lap;
  logic [4*DIGITS-1:0] bcd;
  logic                running;
  logic                lap_active;
  logic                overflow;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DIGITS   (DIGITS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .bcd        (bcd),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;
  } obs_t;

  typedef struct {
    logic  ss;
    logic  cl;
    logic  lp;
    int    waits;
    obs_t  exp;
    string name;
  } step_t;

  obs_t  sb_q[$];
  string nm_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic step_t mk(input logic ss, input logic cl, input logic lp,
                               input int waits, input logic [15:0] b,
                               input logic r, input logic l, input logic o,
                               input string name);
    step_t s;
    s.ss    = ss;
    s.cl    = cl;
    s.lp    = lp;
    s.waits = waits;
    s.exp   = {b, r, l, o};
    s.name  = name;
    return s;
  endfunction

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one step: optional one-edge pulse, then extra edges. The expected
  // result is queued as the stimulus goes out.
  task automatic drive_step(input step_t s);
    sb_q.push_back(s.exp);
    nm_q.push_back(s.name);
    if (s.ss || s.cl || s.lp) begin
      start_stop = s.ss;
      clear      = s.cl;
      lap        = s.lp;
      wait_edges(1);
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      if (s.waits > 0) wait_edges(s.waits);
    end else begin
      wait_edges(s.waits);
    end
  endtask

  // Reset held for two edges (with start_stop asserted, which must lose),
  // then released and left idle. Also used for a reset in mid-count.
  task automatic test_reset();
    obs_t  got, e;
    string nm;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        rst = 1'b1; start_stop = 1'b1; clear = 1'b0; lap = 1'b0;
        sb_q.push_back(obs_t'({16'h0000, 1'b0, 1'b0, 1'b0}));
        nm_q.push_back("reset_asserted");
        wait_edges(2);
      end else begin
        rst = 1'b0; start_stop = 1'b0;
        sb_q.push_back(obs_t'({16'h0000, 1'b0, 1'b0, 1'b0}));
        nm_q.push_back("reset_released_idle");
        wait_edges(5);
      end
      got = {bcd, running, lap_active, overflow};
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got bcd=%h running=%b lap_active=%b overflow=%b, expected bcd=%h running=%b lap_active=%b overflow=%b",
                 nm, got.bcd, got.running, got.lap_active, got.overflow,
                 e.bcd, e.running, e.lap_active, e.overflow);
      end
    end
  endtask

  // start_stop at edge 1: running after edge 1, first increment after
  // edge 5, 0x0009 after edge 37, 0x0010 after edge 41.
  task automatic test_start_timing();
    step_t st[$];
    obs_t  got, e;
    string nm;
    st.push_back(mk(1, 0, 0, 0,  16'h0000, 1, 0, 0, "start_running"));
    st.push_back(mk(0, 0, 0, 3,  16'h0000, 1, 0, 0, "before_first_tick"));
    st.push_back(mk(0, 0, 0, 1,  16'h0001, 1, 0, 0, "first_tick_edge5"));
    st.push_back(mk(0, 0, 0, 32, 16'h0009, 1, 0, 0, "count9_edge37"));
    st.push_back(mk(0, 0, 0, 4,  16'h0010, 1, 0, 0, "carry_edge41"));
    foreach (st[i]) begin
      drive_step(st[i]);
      got = {bcd, running, lap_active, overflow};
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got bcd=%h running=%b lap_active=%b overflow=%b, expected bcd=%h running=%b lap_active=%b overflow=%b",
                 nm, got.bcd, got.running, got.lap_active, got.overflow,
                 e.bcd, e.running, e.lap_active, e.overflow);
      end
    end
  endtask

  // Continues from 0x0010 with pre=0. One edge later pre=1; pausing on the
  // next edge leaves pre=2 held. After resume the next increment lands two
  // edges later.
  task automatic test_pause_resume();
    step_t st[$];
    obs_t  got, e;
    string nm;
    st.push_back(mk(0, 0, 0, 1,  16'h0010, 1, 0, 0, "pre_one"));
    st.push_back(mk(1, 0, 0, 0,  16'h0010, 0, 0, 0, "pause"));
    st.push_back(mk(0, 0, 0, 10, 16'h0010, 0, 0, 0, "paused_hold"));
    st.push_back(mk(1, 0, 0, 0,  16'h0010, 1, 0, 0, "resume"));
    st.push_back(mk(0, 0, 0, 1,  16'h0010, 1, 0, 0, "resume_plus1"));
    st.push_back(mk(0, 0, 0, 1,  16'h0011, 1, 0, 0, "resume_plus2"));
    foreach (st[i]) begin
      drive_step(st[i]);
      got = {bcd, running, lap_active, overflow};
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got bcd=%h running=%b lap_active=%b overflow=%b, expected bcd=%h running=%b lap_active=%b overflow=%b",
                 nm, got.bcd, got.running, got.lap_active, got.overflow,
                 e.bcd, e.running, e.lap_active, e.overflow);
      end
    end
  endtask

  // Start at edge s. Lap at s+29 (count 7) freezes the display for 20
  // edges; the live count reaches 0x0012 at s+48, shown on release at s+50.
  // A lap while paused and not frozen is ignored.
  task automatic test_lap();
    step_t st[$];
    obs_t  got, e;
    string nm;
    st.push_back(mk(0, 1, 0, 0,  16'h0000, 0, 0, 0, "clear_before_lap"));
    st.push_back(mk(1, 0, 0, 0,  16'h0000, 1, 0, 0, "lap_start"));
    st.push_back(mk(0, 0, 0, 28, 16'h0007, 1, 0, 0, "count7"));
    st.push_back(mk(0, 0, 1, 0,  16'h0007, 1, 1, 0, "lap_capture"));
    for (int k = 0; k < 20; k++)
      st.push_back(mk(0, 0, 0, 1, 16'h0007, 1, 1, 0, "lap_hold"));
    st.push_back(mk(0, 0, 1, 0,  16'h0012, 1, 0, 0, "lap_release_live"));
    st.push_back(mk(1, 0, 0, 0,  16'h0012, 0, 0, 0, "pause_after_lap"));
    st.push_back(mk(0, 0, 1, 0,  16'h0012, 0, 0, 0, "lap_ignored_paused"));
    st.push_back(mk(0, 0, 0, 3,  16'h0012, 0, 0, 0, "paused_no_count"));
    foreach (st[i]) begin
      drive_step(st[i]);
      got = {bcd, running, lap_active, overflow};
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got bcd=%h running=%b lap_active=%b overflow=%b, expected bcd=%h running=%b lap_active=%b overflow=%b",
                 nm, got.bcd, got.running, got.lap_active, got.overflow,
                 e.bcd, e.running, e.lap_active, e.overflow);
      end
    end
  endtask

  // clear+start_stop in RUN goes to IDLE with a zeroed prescaler (a stale
  // prescaler would bring the next first tick early). A tick coincident
  // with start_stop still increments. start_stop+lap in RUN pauses and
  // freezes the pre-edge count. clear drops the freeze; lap in IDLE ignored.
  task automatic test_priority();
    step_t st[$];
    obs_t  got, e;
    string nm;
    st.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 0, 0, "clear_first"));
    st.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 0, 0, "prio_start"));
    st.push_back(mk(0, 0, 0, 2, 16'h0000, 1, 0, 0, "prio_run"));
    st.push_back(mk(1, 1, 0, 0, 16'h0000, 0, 0, 0, "clear_beats_start"));
    st.push_back(mk(0, 0, 0, 4, 16'h0000, 0, 0, 0, "idle_after_clear"));
    st.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 0, 0, "restart"));
    st.push_back(mk(0, 0, 0, 3, 16'h0000, 1, 0, 0, "pre_cleared"));
    st.push_back(mk(1, 0, 0, 0, 16'h0001, 0, 0, 0, "tick_then_pause"));
    st.push_back(mk(1, 0, 0, 0, 16'h0001, 1, 0, 0, "resume_again"));
    st.push_back(mk(1, 0, 1, 0, 16'h0001, 0, 1, 0, "stop_and_lap"));
    st.push_back(mk(0, 0, 0, 5, 16'h0001, 0, 1, 0, "frozen_paused"));
    st.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 0, 0, "clear_beats_lap"));
    st.push_back(mk(0, 0, 1, 0, 16'h0000, 0, 0, 0, "lap_ignored_idle"));
    foreach (st[i]) begin
      drive_step(st[i]);
      got = {bcd, running, lap_active, overflow};
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got bcd=%h running=%b lap_active=%b overflow=%b, expected bcd=%h running=%b lap_active=%b overflow=%b",
                 nm, got.bcd, got.running, got.lap_active, got.overflow,
                 e.bcd, e.running, e.lap_active, e.overflow);
      end
    end
  endtask

  // From IDLE, start at edge s; count k appears after edge s+4k. 0x9999 at
  // s+39996, wrap to 0x0000 with overflow at s+40000, overflow low after.
  task automatic test_wrap();
    step_t st[$];
    obs_t  got, e;
    string nm;
    st.push_back(mk(1, 0, 0, 0,     16'h0000, 1, 0, 0, "wrap_start"));
    st.push_back(mk(0, 0, 0, 39995, 16'h9998, 1, 0, 0, "reach_9998"));
    st.push_back(mk(0, 0, 0, 1,     16'h9999, 1, 0, 0, "reach_9999"));
    st.push_back(mk(0, 0, 0, 3,     16'h9999, 1, 0, 0, "pre_wrap"));
    st.push_back(mk(0, 0, 0, 1,     16'h0000, 1, 0, 1, "wrap_overflow"));
    st.push_back(mk(0, 0, 0, 1,     16'h0000, 1, 0, 0, "overflow_one_cycle"));
    st.push_back(mk(0, 0, 0, 3,     16'h0001, 1, 0, 0, "count_after_wrap"));
    foreach (st[i]) begin
      drive_step(st[i]);
      got = {bcd, running, lap_active, overflow};
      e   = sb_q.pop_front();
      nm  = nm_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got bcd=%h running=%b lap_active=%b overflow=%b, expected bcd=%h running=%b lap_active=%b overflow=%b",
                 nm, got.bcd, got.running, got.lap_active, got.overflow,
                 e.bcd, e.running, e.lap_active, e.overflow);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
             checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
    test_reset();
    test_start_timing();
    test_pause_resume();
    test_lap();
    test_priority();
    test_wrap();
    test_reset();  // reset while running with a non-zero count
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_stopwatch_ctrl
